clk_freq_mon: RTL

CLK_FREQ_MON -- requirements
Module: clk_freq_mon

---
 rtl/clk_freq_mon.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/clk_freq_mon.sv
`timescale 1ns/1ps
// clk_freq_mon: counts rising edges of an asynchronous monitored clock over a
// fixed window of reference clk cycles. It can run single or back-to-back
// windows, and it flags a stalled monitored clock.
//
// Ports:
//   clk      reference clock; every flop in the block runs on it
//   rstn     asynchronous active-low reset
//   mon_clk  monitored clock, sampled as asynchronous data
//   start    level-sampled request to begin a window (ignored while busy)
//   cont     repeat windows back-to-back while high
//   abort    end the current window; no result is produced
//   busy     a window is in progress
//   cnt_out  mon_clk rising edges counted in the last completed window
//   cnt_vld  one-cycle pulse when cnt_out/ovf update
//   ovf      the last completed window saturated the edge counter
//   stopped  no mon_clk rising edge for at least TIMEOUT clk cycles
module clk_freq_mon #(
  parameter int unsigned WIN_CYC = 1000,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mon_clk,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_vld,
  output logic             ovf,
  output logic             stopped
);

  localparam int unsigned WIN_W = $clog2(WIN_CYC);
  localparam int unsigned IDL_W = $clog2(TIMEOUT + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
  localparam logic [IDL_W-1:0] IDL_MAX  = IDL_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] EDGE_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               mon_sync1;
  logic               mon_sync2;
  logic               mon_hist;
  logic               rise_c;
  logic [WIN_W-1:0]   win_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic [CNT_W-1:0]   edge_nxt;
  logic               ovf_w;
  logic               ovf_nxt;
  logic               win_end;
  logic [IDL_W-1:0]   idle_cnt;
  logic [IDL_W-1:0]   idle_nxt;

  // Two-flop synchronizer plus history flop; one rise per mon_clk rising edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mon_sync1 <= 1'b0;
      mon_sync2 <= 1'b0;
      mon_hist  <= 1'b0;
    end else begin
      mon_sync1 <= mon_clk;
      mon_sync2 <= mon_sync1;
      mon_hist  <= mon_sync2;
    end
  end

  assign rise_c = mon_sync2 & ~mon_hist;

  // Next-state and saturating next-count logic
  always_comb begin
    state_nxt = state;
    win_end   = (state == MEAS) && (win_cnt == WIN_LAST);
    edge_nxt  = edge_cnt;
    ovf_nxt   = ovf_w;
    if (rise_c) begin
      if (edge_cnt == EDGE_MAX) begin
        ovf_nxt = 1'b1;
      end else begin
        edge_nxt = edge_cnt + CNT_W'(1);
      end
    end
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = MEAS;
        end
      end
      MEAS: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (win_end && !cont) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; busy mirrors the registered state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == MEAS);
    end
  end

  // Window counters and result registers; abort drops the window silently
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
      ovf_w    <= 1'b0;
      cnt_out  <= '0;
      ovf      <= 1'b0;
      cnt_vld  <= 1'b0;
    end else begin
      cnt_vld <= 1'b0;
      if ((state == MEAS) && !abort) begin
        if (win_end) begin
          // Final count includes the rise seen in the last window cycle
          cnt_out  <= edge_nxt;
          ovf      <= ovf_nxt;
          cnt_vld  <= 1'b1;
          win_cnt  <= '0;
          edge_cnt <= '0;
          ovf_w    <= 1'b0;
        end else begin
          win_cnt  <= win_cnt + WIN_W'(1);
          edge_cnt <= edge_nxt;
          ovf_w    <= ovf_nxt;
        end
      end else begin
        win_cnt  <= '0;
        edge_cnt <= '0;
        ovf_w    <= 1'b0;
      end
    end
  end

  // Stall detector runs in every state and saturates at TIMEOUT
  always_comb begin
    idle_nxt = idle_cnt;
    if (rise_c) begin
      idle_nxt = '0;
    end else if (idle_cnt != IDL_MAX) begin
      idle_nxt = idle_cnt + IDL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
      stopped  <= 1'b0;
    end else begin
      idle_cnt <= idle_nxt;
      stopped  <= (idle_nxt == IDL_MAX);
    end
  end

endmodule
